vend_dispense_arbiter: RTL and testbench

Shares one dispenser mechanism between several vending front-end panels, each running its own coin/selection FSM. It grants one panel at a time using round-robin priority and issues a start pulse with the selected item code. It then waits for dispenser completion and returns a per-panel acknowledge. It sits between the panel FSMs and the single dispenser datapath.

---
 rtl/vend_dispense_arbiter_if.sv | 30 +++
 rtl/vend_dispense_arbiter.sv | 175 +++++++++++++++++
 tb/tb_vend_dispense_arbiter.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vend_dispense_arbiter_if.sv
// Panel/dispenser handshake bundle for vend_dispense_arbiter.
// master: the panels and dispenser side that drive requests and completions.
// slave : the arbiter itself.
interface vend_dispense_arbiter_if #(
    parameter int IDW    = 2,
    parameter int ITEM_W = 4
);
    localparam int N_REQ = 2**IDW;

    logic [N_REQ-1:0]        req;
    logic [N_REQ*ITEM_W-1:0] item_code;
    logic                    disp_busy;
    logic                    disp_done;
    logic                    disp_start;
    logic [ITEM_W-1:0]       disp_item;
    logic [IDW-1:0]          grant_id;
    logic                    busy;
    logic [N_REQ-1:0]        ack;
    logic [N_REQ-1:0]        fault;

    modport master (
        output req, item_code, disp_busy, disp_done,
        input  disp_start, disp_item, grant_id, busy, ack, fault
    );

    modport slave (
        input  req, item_code, disp_busy, disp_done,
        output disp_start, disp_item, grant_id, busy, ack, fault
    );
endinterface

// File: rtl/vend_dispense_arbiter.sv
// Round-robin arbiter sharing one dispenser between N_REQ vending panels.
// One transaction at a time: grant, start pulse, wait for done, per-panel ack,
// then a cooldown before the next arbitration.
// Optional WAIT watchdog: define VEND_ARB_TIMEOUT_EN to build the timeout
// counter and fault pulses; otherwise fault is tied to 0.
module vend_dispense_arbiter #(
    parameter int IDW      = 2,
    parameter int ITEM_W   = 4,
    parameter int TIMEOUT  = 200,
    parameter int COOLDOWN = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    vend_dispense_arbiter_if.slave io_arb
);
    localparam int N_REQ  = 2**IDW;
    localparam int COOL_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_ACK,
        S_COOL
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [IDW-1:0]      r_last, w_last_nxt;
    logic [COOL_W-1:0]   r_cool_cnt, w_cool_cnt_nxt;
    logic                r_disp_start, w_disp_start_nxt;
    logic [ITEM_W-1:0]   r_disp_item, w_disp_item_nxt;
    logic [IDW-1:0]      r_grant_id, w_grant_id_nxt;
    logic                r_busy;
    logic [N_REQ-1:0]    r_ack, w_ack_nxt;
    logic [N_REQ-1:0]    w_owner_onehot;
    logic                w_win_found;
    logic [IDW-1:0]      w_win_id;
    logic [IDW-1:0]      w_scan_id;

`ifdef VEND_ARB_TIMEOUT_EN
    localparam int RAW_W = $clog2(TIMEOUT + 1);
    localparam int CNT_W = (RAW_W > 8) ? RAW_W : 8;

    logic [CNT_W-1:0]    r_wait_cnt, w_wait_cnt_nxt;
    logic [N_REQ-1:0]    r_fault, w_fault_nxt;
    logic                w_timeout_hit;

    // Counter would reach TIMEOUT on this WAIT cycle
    assign w_timeout_hit = (r_wait_cnt == CNT_W'(TIMEOUT - 1));
`else
    logic                w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT > 0);
`endif

    assign w_owner_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << r_grant_id;

    // Round-robin scan starting just after the last served panel
    always_comb begin
        // NOTE: every variable written here gets a default first, otherwise paths that skip an assignment infer a latch.
        w_win_found = 1'b0;
        w_win_id    = r_last;
        w_scan_id   = r_last;
        for (int i = 1; i <= N_REQ; i++) begin
            w_scan_id = r_last + IDW'(i);
            if (!w_win_found && io_arb.req[w_scan_id]) begin
                w_win_found = 1'b1;
                w_win_id    = w_scan_id;
            end
        end
    end

    // Next-state and next-output logic; outputs are registered from these
    always_comb begin
        w_state_nxt      = r_state;
        w_last_nxt       = r_last;
        w_cool_cnt_nxt   = r_cool_cnt;
        w_disp_start_nxt = 1'b0;
        w_disp_item_nxt  = r_disp_item;
        w_grant_id_nxt   = r_grant_id;
        w_ack_nxt        = '0;
`ifdef VEND_ARB_TIMEOUT_EN
        w_wait_cnt_nxt   = r_wait_cnt;
        w_fault_nxt      = '0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_win_found && !io_arb.disp_busy) begin
                    w_state_nxt      = S_START;
                    w_disp_start_nxt = 1'b1;
                    w_grant_id_nxt   = w_win_id;
                    w_disp_item_nxt  = io_arb.item_code[w_win_id*ITEM_W +: ITEM_W];
                end
            end
            S_START: begin
                w_state_nxt = S_WAIT;
`ifdef VEND_ARB_TIMEOUT_EN
                w_wait_cnt_nxt = '0;
`endif
            end
            S_WAIT: begin
                // A done in the same cycle as the timeout still wins
                if (io_arb.disp_done) begin
                    w_state_nxt = S_ACK;
                    w_ack_nxt   = w_owner_onehot;
                    w_last_nxt  = r_grant_id;
                end
`ifdef VEND_ARB_TIMEOUT_EN
                else if (w_timeout_hit) begin
                    w_state_nxt    = S_COOL;
                    w_fault_nxt    = w_owner_onehot;
                    w_last_nxt     = r_grant_id;
                    w_cool_cnt_nxt = '0;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 1'b1;
                end
`endif
            end
            S_ACK: begin
                w_state_nxt    = S_COOL;
                w_cool_cnt_nxt = '0;
            end
            S_COOL: begin
                if (r_cool_cnt == COOL_W'(COOLDOWN - 1)) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cool_cnt_nxt = r_cool_cnt + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and output registers; reset forces IDLE with all outputs low
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_last       <= '1;
            r_cool_cnt   <= '0;
            r_disp_start <= 1'b0;
            r_disp_item  <= '0;
            r_grant_id   <= '0;
            r_busy       <= 1'b0;
            r_ack        <= '0;
`ifdef VEND_ARB_TIMEOUT_EN
            r_wait_cnt   <= '0;
            r_fault      <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values together.
            r_state      <= w_state_nxt;
            r_last       <= w_last_nxt;
            r_cool_cnt   <= w_cool_cnt_nxt;
            r_disp_start <= w_disp_start_nxt;
            r_disp_item  <= w_disp_item_nxt;
            r_grant_id   <= w_grant_id_nxt;
            r_busy       <= (w_state_nxt != S_IDLE);
            r_ack        <= w_ack_nxt;
`ifdef VEND_ARB_TIMEOUT_EN
            r_wait_cnt   <= w_wait_cnt_nxt;
            r_fault      <= w_fault_nxt;
`endif
        end
    end

    assign io_arb.disp_start = r_disp_start;
    assign io_arb.disp_item  = r_disp_item;
    assign io_arb.grant_id   = r_grant_id;
    assign io_arb.busy       = r_busy;
    assign io_arb.ack        = r_ack;
`ifdef VEND_ARB_TIMEOUT_EN
    assign io_arb.fault      = r_fault;
`else
    assign io_arb.fault      = '0;
`endif
endmodule

// File: tb/tb_vend_dispense_arbiter.sv
// Self-checking bench for vend_dispense_arbiter: a timeline model predicts
// start/ack/fault/busy cycles and the grant winner, directed scenarios pin
// the model with literal expectations, then a randomized run follows.
module tb_vend_dispense_arbiter;
    localparam int IDW      = 2;
    localparam int ITEM_W   = 4;
    localparam int N_REQ    = 4;
    localparam int COOLDOWN = 2;
`ifdef VEND_ARB_TIMEOUT_EN
    localparam int TIMEOUT  = 20;
    localparam bit TO_EN    = 1'b1;
`else
    localparam int TIMEOUT  = 200;
    localparam bit TO_EN    = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    vend_dispense_arbiter_if #(.IDW(IDW), .ITEM_W(ITEM_W)) bus ();

    vend_dispense_arbiter #(
        .IDW(IDW), .ITEM_W(ITEM_W), .TIMEOUT(TIMEOUT), .COOLDOWN(COOLDOWN)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .io_arb(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- timeline reference model ----------------
    bit               m_active = 1'b0;
    int               m_start = 0, m_resp = -1, m_idle_from = 0;
    bit               m_is_fault = 1'b0;
    int               m_last = N_REQ - 1, m_gid = 0;
    logic [ITEM_W-1:0] m_item = '0;

    task automatic model_check();
        logic [N_REQ-1:0] exp_ack, exp_fault;
        exp_ack   = '0;
        exp_fault = '0;
        if (m_active && cyc == m_resp) begin
            if (m_is_fault) exp_fault[m_gid] = 1'b1;
            else            exp_ack[m_gid]   = 1'b1;
        end
        check("disp_start", 32'(bus.disp_start), 32'(m_active && cyc == m_start));
        check("busy", 32'(bus.busy), 32'(m_active || cyc < m_idle_from));
        check("ack", 32'(bus.ack), 32'(exp_ack));
        check("fault", 32'(bus.fault), 32'(exp_fault));
        if (m_active && cyc >= m_start) begin
            check("grant_id", 32'(bus.grant_id), 32'(m_gid));
            check("disp_item", 32'(bus.disp_item), 32'(m_item));
        end
    endtask

    // Advance the model using the inputs the DUT samples at the end of this cycle
    task automatic model_update();
        bit found;
        int idx;
        if (m_active && cyc == m_resp) begin
            m_last      = m_gid;
            m_idle_from = m_is_fault ? cyc + COOLDOWN : cyc + COOLDOWN + 1;
            m_active    = 1'b0;
        end else if (m_active && m_resp < 0 && cyc >= m_start + 1) begin
            if (bus.disp_done) begin
                m_resp = cyc + 1; m_is_fault = 1'b0;
            end else if (TO_EN && cyc == m_start + TIMEOUT) begin
                m_resp = cyc + 1; m_is_fault = 1'b1;
            end
        end else if (!m_active && cyc >= m_idle_from && (|bus.req) && !bus.disp_busy) begin
            found = 1'b0;
            for (int k = 1; k <= N_REQ; k++) begin
                idx = (m_last + k) % N_REQ;
                if (!found && bus.req[idx]) begin
                    found = 1'b1;
                    m_gid = idx;
                end
            end
            m_active = 1'b1;
            m_start  = cyc + 1;
            m_resp   = -1;
            m_item   = bus.item_code[m_gid*ITEM_W +: ITEM_W];
        end
    endtask

    // ---------------- stimulus state ----------------
    logic [N_REQ-1:0]        req_v  = '0;
    logic [N_REQ*ITEM_W-1:0] code_v = '0;
    logic                    busy_v = 1'b0;
    bit  auto_rel = 1'b1, auto_dsp = 1'b1, rand_mode = 1'b0, spur_done = 1'b0;
    int  dsp_delay = 1, done_at = -1;
    int  n_starts = 0, n_acks = 0, n_faults = 0, last_ack_cyc = -1, last_fault_cyc = -1;
    int  grants[$];
    int  start_cycs[$];
    int  start_items[$];

    task automatic rand_inputs();
        for (int i = 0; i < N_REQ; i++) begin
            if (!req_v[i] && $urandom_range(3) == 0) begin
                req_v[i] = 1'b1;
                code_v[i*ITEM_W +: ITEM_W] = ITEM_W'($urandom);
            end
        end
        if (bus.busy && $urandom_range(15) == 0) req_v[bus.grant_id] = 1'b0;
        busy_v    = ($urandom_range(3) == 0);
        spur_done = ($urandom_range(7) == 0);
    endtask

    task automatic cycle();
        @(negedge clk);
        cyc++;
        model_check();
        if (bus.disp_start === 1'b1) begin
            n_starts++;
            grants.push_back(int'(bus.grant_id));
            start_cycs.push_back(cyc);
            start_items.push_back(int'(bus.disp_item));
            if (rand_mode) begin
                if (TO_EN && $urandom_range(4) == 0) dsp_delay = int'($urandom_range(24, 18));
                else                                 dsp_delay = int'($urandom_range(6, 1));
            end
            if (auto_dsp) done_at = cyc + dsp_delay;
        end
        if (|bus.ack)   begin n_acks++;   last_ack_cyc   = cyc; end
        if (|bus.fault) begin n_faults++; last_fault_cyc = cyc; end
        if (auto_rel) req_v &= ~(bus.ack | bus.fault);
        if (rand_mode) rand_inputs();
        else           spur_done = 1'b0;
        bus.req       = req_v;
        bus.item_code = code_v;
        bus.disp_busy = busy_v;
        bus.disp_done = (auto_dsp && cyc == done_at) || spur_done;
        model_update();
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_until_starts(int target, int budget);
        int n = 0;
        while (n_starts < target && n < budget) begin
            cycle();
            n++;
        end
        check("start_budget", 32'(n_starts >= target), 32'd1);
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_disp_start"}, 32'(bus.disp_start), 32'd0);
        check({tag, "_disp_item"},  32'(bus.disp_item),  32'd0);
        check({tag, "_grant_id"},   32'(bus.grant_id),   32'd0);
        check({tag, "_busy"},       32'(bus.busy),       32'd0);
        check({tag, "_ack"},        32'(bus.ack),        32'd0);
        check({tag, "_fault"},      32'(bus.fault),      32'd0);
    endtask

    // Asynchronous reset placed mid-cycle, released on a falling edge
    task automatic do_reset(string tag);
        #3;
        reset_n = 1'b0;
        req_v = '0; busy_v = 1'b0; done_at = -1;
        bus.req = '0; bus.disp_busy = 1'b0; bus.disp_done = 1'b0;
        #1;
        check_all_zero(tag);
        repeat (2) @(negedge clk);
        reset_n     = 1'b1;
        m_active    = 1'b0;
        m_idle_from = cyc + 1;
        m_last      = N_REQ - 1;
    endtask

    initial begin
        int base, c0, cb, acks0;
        bus.req = '0; bus.item_code = '0; bus.disp_busy = 1'b0; bus.disp_done = 1'b0;
        do_reset("reset");

        // Single request from panel 0, done 3 cycles after start
        auto_rel = 1'b1; auto_dsp = 1'b1; dsp_delay = 3;
        req_v = 4'b0001; code_v = 16'h0005;
        base = grants.size();
        cycle();
        c0 = cyc;
        run(12);
        check("t1_starts", 32'(grants.size() - base), 32'd1);
        if (grants.size() > base) begin
            check("t1_start_cycle", 32'(start_cycs[base]), 32'(c0 + 1));
            check("t1_grant", 32'(grants[base]), 32'd0);
            check("t1_item", 32'(start_items[base]), 32'h5);
            check("t1_ack_cycle", 32'(last_ack_cyc), 32'(start_cycs[base] + 4));
        end

        // All panels held high from reset: 0,1,2,3,0
        do_reset("reset2");
        auto_rel = 1'b0; dsp_delay = 1;
        req_v = 4'b1111; code_v = 16'hCBA9;
        base = grants.size();
        run_until_starts(n_starts + 5, 60);
        req_v = '0; auto_rel = 1'b1;
        run(20);
        for (int i = 0; i < 5; i++) begin
            if (grants.size() > base + i) check("t2_order", 32'(grants[base + i]), 32'(i % N_REQ));
        end
        check("t2_item_p3", (grants.size() > base + 3) ? 32'(start_items[base + 3]) : 32'hFFFF, 32'hC);

        // Pointer wrap: grant 1, then 1010 gives 3 then 1
        base = grants.size();
        req_v = 4'b0010;
        run_until_starts(n_starts + 1, 20);
        run(10);
        req_v = 4'b1010;
        run_until_starts(n_starts + 2, 40);
        run(20);
        for (int i = 0; i < 3; i++) begin
            if (grants.size() > base + i) check("t3_wrap", 32'(grants[base + i]), (i == 1) ? 32'd3 : 32'd1);
        end

        // Dispenser busy blocks arbitration
        base = grants.size();
        busy_v = 1'b1; req_v = 4'b0100;
        run(10);
        check("t4_no_start", 32'(grants.size() - base), 32'd0);
        busy_v = 1'b0;
        cycle();
        cb = cyc;
        run(10);
        if (grants.size() > base) begin
            check("t4_start_cycle", 32'(start_cycs[base]), 32'(cb + 1));
            check("t4_grant", 32'(grants[base]), 32'd2);
        end else begin
            check("t4_start_seen", 32'd0, 32'(1));
        end

`ifdef VEND_ARB_TIMEOUT_EN
        // Watchdog: no done at all
        auto_dsp = 1'b0; done_at = -1;
        acks0 = n_acks;
        base = grants.size();
        req_v = 4'b0001;
        run(40);
        check("t5_acks", 32'(n_acks - acks0), 32'd0);
        if (grants.size() > base)
            check("t5_fault_delay", 32'(last_fault_cyc - start_cycs[base]), 32'd21);
        auto_dsp = 1'b1;
        run(10);
`else
        acks0 = n_acks;
`endif

        // Reset in the middle of WAIT, then 0011 grants 0 first
        dsp_delay = 50;
        req_v = 4'b0100;
        run_until_starts(n_starts + 1, 20);
        run(3);
        do_reset("midwait");
        dsp_delay = 2;
        base = grants.size();
        req_v = 4'b0011;
        run_until_starts(n_starts + 1, 20);
        run(20);
        if (grants.size() > base) check("t6_first_grant", 32'(grants[base]), 32'd0);

        // Randomized traffic checked cycle-by-cycle against the model
        rand_mode = 1'b1;
        run(3000);
        rand_mode = 1'b0; req_v = '0; busy_v = 1'b0;
        run(60);
        check("final_idle", 32'(bus.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end
endmodule
